// File: rtl/gpu_net_tx_arbiter_pkg.sv
// Shared NoC definitions for the GPU network transmit arbiter: flit field layout and output-register states.
package gpu_net_tx_arbiter_pkg;

    localparam int DEST_MSB  = 15;
    localparam int DEST_LSB  = 10;
    localparam int PAYLOAD_W = 10;
    localparam int FLIT_W    = 16;
    localparam int DEST_W    = DEST_MSB - DEST_LSB + 1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } tx_state_t;

    function automatic logic [DEST_W-1:0] flit_dest(input logic [FLIT_W-1:0] flit);
        return flit[DEST_MSB:DEST_LSB];
    endfunction

endpackage

// File: rtl/gpu_net_tx_arbiter_rr_arbiter.sv
// Combinational round-robin search: the first valid request at or after ptr+1 (mod N_REQ) wins.
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [2:0]       ptr,
    output logic [N_REQ-1:0] grant,
    output logic [2:0]       grant_idx,
    output logic             grant_any
);

    logic [7:0] req_ext;
    logic [3:0] cand;

    always_comb begin
        req_ext            = '0;
        req_ext[N_REQ-1:0] = req;
        grant_idx          = '0;
        grant_any          = 1'b0;
        cand               = '0;
        // ptr+1+i never exceeds 2*N_REQ-1, so one conditional subtract gives the modulo
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = {1'b0, ptr} + 4'd1 + 4'(i);
            if (cand >= 4'(N_REQ))
                cand = cand - 4'(N_REQ);
            if (!grant_any && req_ext[cand[2:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[2:0];
            end
        end
    end

    always_comb begin
        grant = '0;
        for (int unsigned k = 0; k < N_REQ; k++)
            grant[k] = grant_any && (grant_idx == 3'(k));
    end

endmodule

// File: rtl/gpu_net_tx_arbiter.sv
// Round-robin merge of N_REQ flit requesters into one registered network output; self-addressed flits are dropped.
module gpu_net_tx_arbiter #(
    parameter int GPU_ID = 14,
    parameter int N_REQ  = 4,
    parameter int FLIT_W = 16
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*FLIT_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic [FLIT_W-1:0]       net_data_out,
    output logic                    net_valid_out,
    input  logic                    net_ready_in,
    output logic [2:0]              grant_id,
    output logic                    drop_pulse,
    output logic [15:0]             sent_cnt
);
    import gpu_net_tx_arbiter_pkg::*;

    localparam logic [DEST_W-1:0] LOCAL_ID = DEST_W'(GPU_ID);

    tx_state_t         state;
    logic [2:0]        last_grant;
    logic [N_REQ-1:0]  arb_grant;
    logic [2:0]        arb_idx;
    logic              arb_any;
    logic              accept_slot;
    logic              take;
    logic              self_addr;
    logic [FLIT_W-1:0] sel_flit;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req       (req_valid),
        .ptr       (last_grant),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .grant_any (arb_any)
    );

    assign accept_slot   = !ARESET && ((state == ST_EMPTY) || net_ready_in);
    assign take          = accept_slot && arb_any;
    assign req_ready     = take ? arb_grant : '0;
    assign net_valid_out = (state == ST_FULL);

    always_comb begin
        sel_flit = '0;
        for (int unsigned k = 0; k < N_REQ; k++)
            if (arb_grant[k])
                sel_flit = req_data[k*FLIT_W +: FLIT_W];
    end

    assign self_addr = (flit_dest(sel_flit) == LOCAL_ID);

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state        <= ST_EMPTY;
            net_data_out <= '0;
            grant_id     <= '0;
            drop_pulse   <= 1'b0;
            sent_cnt     <= '0;
            last_grant   <= 3'(N_REQ - 1);
        end else begin
            drop_pulse <= 1'b0;
            if (state == ST_FULL && net_ready_in) begin
                sent_cnt <= sent_cnt + 16'd1;
                state    <= ST_EMPTY;
            end
            // a dropped flit consumes its grant slot but never touches the output register
            if (take) begin
                last_grant <= arb_idx;
                if (self_addr) begin
                    drop_pulse <= 1'b1;
                end else begin
                    state        <= ST_FULL;
                    net_data_out <= sel_flit;
                    grant_id     <= arb_idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_gpu_net_tx_arbiter.sv
// Randomized and directed bench for gpu_net_tx_arbiter against a cycle-level behavioural model.
module tb_gpu_net_tx_arbiter;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int ID = 14;

    logic           ACLK = 1'b0;
    logic           ARESET;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   net_data_out;
    logic           net_valid_out;
    logic           net_ready_in;
    logic [2:0]     grant_id;
    logic           drop_pulse;
    logic [15:0]    sent_cnt;

    gpu_net_tx_arbiter #(.GPU_ID(ID), .N_REQ(N), .FLIT_W(W)) dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .net_data_out  (net_data_out),
        .net_valid_out (net_valid_out),
        .net_ready_in  (net_ready_in),
        .grant_id      (grant_id),
        .drop_pulse    (drop_pulse),
        .sent_cnt      (sent_cnt)
    );

    always #5 ACLK = ~ACLK;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit          m_full;
    logic [15:0] m_data;
    int          m_gid;
    int          m_last;
    bit          m_drop;
    logic [15:0] m_sent;

    // Requester-side stimulus
    bit          pend [N];
    bit          held [N];
    logic [15:0] pflit[N];
    bit          rst_in;
    bit          rdy_in;
    int          grant_log[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_full = 1'b0;
        m_data = '0;
        m_gid  = 0;
        m_last = N - 1;
        m_drop = 1'b0;
        m_sent = '0;
    endfunction

    function automatic logic [15:0] rand_flit(input bit allow_self);
        logic [5:0] d;
        d = (allow_self && $urandom_range(0, 5) == 0) ? 6'(ID) : 6'($urandom_range(0, 63));
        if (!allow_self && d == 6'(ID))
            d = 6'(ID + 1);
        return {d, 10'($urandom)};
    endfunction

    task automatic refill(input int pct, input bit allow_self);
        for (int k = 0; k < N; k++)
            if (!pend[k] && $urandom_range(0, 99) < pct) begin
                pend[k]  = 1'b1;
                pflit[k] = rand_flit(allow_self);
            end
    endtask

    // One clock: drive, check pre-edge outputs against the model, then advance the model across the edge.
    task automatic cycle();
        int          winner;
        logic [N-1:0] exp_rdy;
        ARESET       = rst_in;
        net_ready_in = rdy_in;
        for (int k = 0; k < N; k++) begin
            req_valid[k]       = pend[k];
            req_data[k*W +: W] = pflit[k];
        end
        #1;
        winner = -1;
        if (!rst_in && (!m_full || rdy_in))
            for (int i = 0; i < N; i++)
                if (winner < 0 && pend[(m_last + 1 + i) % N])
                    winner = (m_last + 1 + i) % N;
        exp_rdy = '0;
        if (winner >= 0)
            exp_rdy[winner] = 1'b1;
        for (int k = 0; k < N; k++)
            if (held[k])
                chk("hold_valid", 32'(req_valid[k]), 32'd1);
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("valid", 32'(net_valid_out), 32'(m_full));
        chk("data", 32'(net_data_out), 32'(m_data));
        chk("gid", 32'(grant_id), 32'(m_gid));
        chk("drop", 32'(drop_pulse), 32'(m_drop));
        chk("sent", 32'(sent_cnt), 32'(m_sent));
        @(posedge ACLK);
        if (rst_in) begin
            model_reset();
        end else begin
            m_drop = 1'b0;
            if (m_full && rdy_in) begin
                m_sent = m_sent + 16'd1;
                m_full = 1'b0;
            end
            if (winner >= 0) begin
                m_last = winner;
                if (pflit[winner][15:10] == 6'(ID)) begin
                    m_drop = 1'b1;
                end else begin
                    m_full = 1'b1;
                    m_data = pflit[winner];
                    m_gid  = winner;
                end
                pend[winner] = 1'b0;
                grant_log.push_back(winner);
            end
        end
        for (int k = 0; k < N; k++)
            held[k] = pend[k];
        @(negedge ACLK);
    endtask

    task automatic reset_dut();
        for (int k = 0; k < N; k++) begin
            pend[k] = 1'b0;
            held[k] = 1'b0;
        end
        rst_in = 1'b1;
        cycle();
        cycle();
        rst_in = 1'b0;
        grant_log.delete();
    endtask

    function automatic int first_grant();
        return (grant_log.size() > 0) ? grant_log[0] : -1;
    endfunction

    initial begin
        ARESET       = 1'b1;
        req_valid    = '0;
        req_data     = '0;
        net_ready_in = 1'b0;
        rst_in       = 1'b1;
        rdy_in       = 1'b0;
        for (int k = 0; k < N; k++) begin
            pend[k]  = 1'b0;
            held[k]  = 1'b0;
            pflit[k] = '0;
        end
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        model_reset();
        chk("rst_valid", 32'(net_valid_out), 32'd0);
        chk("rst_data", 32'(net_data_out), 32'd0);
        chk("rst_gid", 32'(grant_id), 32'd0);
        chk("rst_drop", 32'(drop_pulse), 32'd0);
        chk("rst_sent", 32'(sent_cnt), 32'd0);

        // requests present while reset is held must not be granted
        for (int k = 0; k < N; k++) begin
            pend[k]  = 1'b1;
            pflit[k] = rand_flit(1'b0);
        end
        rdy_in = 1'b1;
        cycle();
        chk("rst_ready", 32'(req_ready), 32'd0);

        // single request
        reset_dut();
        pend[0]  = 1'b1;
        pflit[0] = 16'h3D23;
        cycle();
        chk("s1_valid", 32'(net_valid_out), 32'd1);
        chk("s1_data", 32'(net_data_out), 32'h3D23);
        chk("s1_gid", 32'(grant_id), 32'd0);
        cycle();
        chk("s1_cnt", 32'(sent_cnt), 32'd1);

        // round-robin with all requesters continuously valid
        reset_dut();
        rdy_in = 1'b1;
        repeat (9) begin
            refill(100, 1'b0);
            cycle();
        end
        for (int i = 0; i < 8; i++)
            chk("rr_order", 32'(grant_log[i]), 32'(i % 4));
        chk("rr_cnt", 32'(sent_cnt), 32'd8);

        // backpressure: held flit came from requester 0 (ninth grant)
        rdy_in = 1'b0;
        repeat (5) begin
            refill(100, 1'b0);
            cycle();
        end
        chk("bp_gid", 32'(grant_id), 32'd0);
        chk("bp_ready", 32'(req_ready), 32'd0);
        grant_log.delete();
        rdy_in = 1'b1;
        cycle();
        chk("bp_next", 32'(first_grant()), 32'd1);

        // self-addressed drop
        reset_dut();
        rdy_in   = 1'b1;
        pend[2]  = 1'b1;
        pflit[2] = 16'h3800;
        cycle();
        chk("drop_pulse", 32'(drop_pulse), 32'd1);
        chk("drop_valid", 32'(net_valid_out), 32'd0);
        cycle();
        chk("drop_pulse_end", 32'(drop_pulse), 32'd0);
        chk("drop_cnt", 32'(sent_cnt), 32'd0);

        // mid-transfer reset
        reset_dut();
        for (int k = 0; k < N; k++) begin
            pend[k]  = 1'b1;
            pflit[k] = rand_flit(1'b0);
        end
        rdy_in = 1'b0;
        cycle();
        pend[0]  = 1'b1;
        pflit[0] = rand_flit(1'b0);
        cycle();
        rst_in = 1'b1;
        cycle();
        rst_in = 1'b0;
        chk("mr_valid", 32'(net_valid_out), 32'd0);
        chk("mr_cnt", 32'(sent_cnt), 32'd0);
        grant_log.delete();
        rdy_in = 1'b1;
        cycle();
        chk("mr_first", 32'(first_grant()), 32'd0);

        // counter wrap after 65536 deliveries
        reset_dut();
        rdy_in = 1'b1;
        repeat (65536) begin
            pend[0]  = 1'b1;
            pflit[0] = {6'd1, 10'($urandom)};
            cycle();
        end
        chk("pre_wrap", 32'(sent_cnt), 32'hFFFF);
        cycle();
        chk("wrap", 32'(sent_cnt), 32'h0000);

        // randomized traffic with backpressure and self-addressed flits
        reset_dut();
        repeat (3000) begin
            rdy_in = ($urandom_range(0, 3) != 0);
            refill(40, 1'b1);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
